cuenta_regresiva_timer: RTL and testbench

Countdown stage downstream of the timer-setting counter. It loads the user-set BCD hours/minutes/seconds, decrements them once per second while running, and raises an alarm flag on reaching 00:00:00. Its outputs feed the display multiplexer and the alarm/buzzer logic.

---
 rtl/cuenta_regresiva_timer_pkg.sv | 24 ++
 rtl/cuenta_regresiva_timer_if.sv | 30 +++
 rtl/cuenta_regresiva_timer_decrementador_bcd.sv | 27 ++
 rtl/cuenta_regresiva_timer.sv | 95 +++++++++
 tb/tb_cuenta_regresiva_timer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cuenta_regresiva_timer_pkg.sv
// Shared types and BCD limits for the countdown timer slice.
// Also holds the load-time clamp applied to each user-set field.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSA = 2'd2,
    DONE  = 2'd3
  } estado_t;

  localparam logic [7:0] BCD_MAX_SEG = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_HOR = 8'h23;

  localparam int NUM_CAMPOS = 3;

  // A field with a non-decimal nibble or out of range saturates to its maximum.
  function automatic logic [7:0] sanear_bcd(input logic [7:0] v, input logic [7:0] max_v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/cuenta_regresiva_timer_if.sv
// Control pulses, BCD set values and countdown outputs between the setting
// counter / display logic (master) and the countdown stage (slave).
interface cuenta_regresiva_timer_if;
  logic       carga;
  logic       iniciar;
  logic       pausar;
  logic       apagar;
  logic [7:0] segundos_in;
  logic [7:0] minutos_in;
  logic [7:0] horas_in;
  logic [7:0] segundos_out;
  logic [7:0] minutos_out;
  logic [7:0] horas_out;
  logic       corriendo;
  logic       alarma;

  modport master (
    output carga, iniciar, pausar, apagar,
    output segundos_in, minutos_in, horas_in,
    input  segundos_out, minutos_out, horas_out,
    input  corriendo, alarma
  );

  modport slave (
    input  carga, iniciar, pausar, apagar,
    input  segundos_in, minutos_in, horas_in,
    output segundos_out, minutos_out, horas_out,
    output corriendo, alarma
  );
endinterface

// File: rtl/cuenta_regresiva_timer_decrementador_bcd.sv
// Two-digit BCD decrement of one time field; chained through the borrow so
// seconds feed minutes and minutes feed hours.
module decrementador_bcd #(
  parameter logic [7:0] WRAP = 8'h59
) (
  input  logic [7:0] valor,
  input  logic       borrow_in,
  output logic [7:0] valor_nuevo,
  output logic       borrow_out
);

  always_comb begin
    valor_nuevo = valor;
    borrow_out  = 1'b0;
    if (borrow_in) begin
      if (valor == 8'h00) begin
        valor_nuevo = WRAP;
        borrow_out  = 1'b1;
      end else if (valor[3:0] == 4'd0) begin
        valor_nuevo = {valor[7:4] - 4'd1, 4'd9};
      end else begin
        valor_nuevo = {valor[7:4], valor[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/cuenta_regresiva_timer.sv
// Countdown stage: loads sanitised BCD h:m:s, decrements once per second in
// RUN, and raises alarma when the count lands on 00:00:00.
module cuenta_regresiva_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input logic                    clk,
  input logic                    reset,
  cuenta_regresiva_timer_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  // Field 0 = seconds, 1 = minutes, 2 = hours.
  localparam logic [NUM_CAMPOS-1:0][7:0] WRAPS = {BCD_MAX_HOR, BCD_MAX_MIN, BCD_MAX_SEG};

  estado_t                      estado, estado_nxt;
  logic [PW-1:0]                presc, presc_nxt;
  logic [NUM_CAMPOS-1:0][7:0]   valor, valor_nxt, valor_dec, valor_carga;
  logic [NUM_CAMPOS:0]          borrow;
  logic                         tick, valor_cero, dec_cero;

  assign valor_carga = {sanear_bcd(bus.horas_in,    BCD_MAX_HOR),
                        sanear_bcd(bus.minutos_in,  BCD_MAX_MIN),
                        sanear_bcd(bus.segundos_in, BCD_MAX_SEG)};

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_CAMPOS; i++) begin : g_dec
    decrementador_bcd #(.WRAP(WRAPS[i])) u_dec (
      .valor       (valor[i]),
      .borrow_in   (borrow[i]),
      .valor_nuevo (valor_dec[i]),
      .borrow_out  (borrow[i+1])
    );
  end

  assign tick       = (estado == RUN) && (presc == PRESC_MAX);
  assign valor_cero = (valor == '0);
  assign dec_cero   = (valor_dec == '0);

  always_comb begin
    estado_nxt = estado;
    presc_nxt  = presc;
    valor_nxt  = valor;
    if (bus.carga) begin
      valor_nxt  = valor_carga;
      presc_nxt  = '0;
      estado_nxt = IDLE;
    end else begin
      unique case (estado)
        IDLE:  if (bus.iniciar && !valor_cero) estado_nxt = RUN;
        RUN: begin
          // Pause freezes the prescaler on its own edge, so a pause that
          // lands on a tick leaves it at the last count and loses nothing.
          if (bus.pausar) begin
            estado_nxt = PAUSA;
          end else if (tick) begin
            presc_nxt = '0;
            // A borrow out of hours would mean underflow; never commit it.
            if (!borrow[NUM_CAMPOS]) begin
              valor_nxt = valor_dec;
              if (dec_cero) estado_nxt = DONE;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        PAUSA: if (bus.iniciar) estado_nxt = RUN;
        DONE:  if (bus.apagar)  estado_nxt = IDLE;
        default: estado_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado <= IDLE;
      presc  <= '0;
      valor  <= '0;
    end else begin
      estado <= estado_nxt;
      presc  <= presc_nxt;
      valor  <= valor_nxt;
    end
  end

  assign bus.segundos_out = valor[0];
  assign bus.minutos_out  = valor[1];
  assign bus.horas_out    = valor[2];
  assign bus.corriendo    = (estado == RUN);
  assign bus.alarma       = (estado == DONE);

endmodule

// File: tb/tb_cuenta_regresiva_timer.sv
// Bench for cuenta_regresiva_timer: directed sequences, a load-sanitising
// table, and random pulses checked against a seconds-count reference model.
module tb_cuenta_regresiva_timer;

  localparam int TPS = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSA = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cuenta_regresiva_timer_if bus();

  cuenta_regresiva_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining time as a plain count of seconds.
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_phase = 0;

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic int clamp(input logic [7:0] v, input int max_n);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return max_n;
    if (bcd2int(v) > max_n) return max_n;
    return bcd2int(v);
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0;
    end else if (bus.carga) begin
      m_secs  = clamp(bus.horas_in, 23) * 3600 + clamp(bus.minutos_in, 59) * 60
              + clamp(bus.segundos_in, 59);
      m_phase = 0;
      m_mode  = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (bus.iniciar && m_secs != 0) m_mode = M_RUN;
        M_PAUSA: if (bus.iniciar) m_mode = M_PAUSA + (M_RUN - M_PAUSA);
        M_DONE:  if (bus.apagar) m_mode = M_IDLE;
        default: begin
          if (bus.pausar) m_mode = M_PAUSA;
          else if (m_phase == TPS - 1) begin
            m_phase = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) m_mode = M_DONE;
          end else m_phase = m_phase + 1;
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [7:0] h, input logic [7:0] m,
                     input logic [7:0] s, input logic co, input logic al);
    n_cmp++;
    if ({bus.horas_out, bus.minutos_out, bus.segundos_out, bus.corriendo, bus.alarma}
        !== {h, m, s, co, al}) begin
      n_bad++;
      $display("FAIL %s: got %h:%h:%h corriendo=%b alarma=%b, want %h:%h:%h corriendo=%b alarma=%b",
               name, bus.horas_out, bus.minutos_out, bus.segundos_out, bus.corriendo, bus.alarma,
               h, m, s, co, al);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, int2bcd(m_secs / 3600), int2bcd((m_secs / 60) % 60), int2bcd(m_secs % 60),
        m_mode == M_RUN, m_mode == M_DONE);
  endtask

  // One clock edge with whatever inputs are currently applied; pulses drop after.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
      bus.carga = 1'b0; bus.iniciar = 1'b0; bus.pausar = 1'b0; bus.apagar = 1'b0;
    end
  endtask

  task automatic cargar(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.horas_in = h; bus.minutos_in = m; bus.segundos_in = s;
    bus.carga = 1'b1;
    cyc();
  endtask

  task automatic iniciar();
    bus.iniciar = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic [7:0] s_in, m_in, h_in;
    logic [7:0] s_exp, m_exp, h_exp;
  } vec_t;

  vec_t tabla[8];

  initial begin
    tabla[0] = '{8'h7A, 8'h65, 8'h30, 8'h59, 8'h59, 8'h23};
    tabla[1] = '{8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 8'h23};
    tabla[2] = '{8'h5A, 8'h00, 8'h2A, 8'h59, 8'h00, 8'h23};
    tabla[3] = '{8'h60, 8'h99, 8'h24, 8'h59, 8'h59, 8'h23};
    tabla[4] = '{8'hA0, 8'h0F, 8'h19, 8'h59, 8'h59, 8'h19};
    tabla[5] = '{8'h12, 8'h34, 8'h09, 8'h12, 8'h34, 8'h09};
    tabla[6] = '{8'h99, 8'h60, 8'hF0, 8'h59, 8'h59, 8'h23};
    tabla[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    bus.carga = 0; bus.iniciar = 0; bus.pausar = 0; bus.apagar = 0;
    bus.segundos_in = 0; bus.minutos_in = 0; bus.horas_in = 0;

    // Reset
    reset = 1'b0;
    cyc(2);
    chk("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;

    // Basic countdown with second/minute borrow
    cargar(8'h00, 8'h01, 8'h02);
    chk("load_0102", 8'h00, 8'h01, 8'h02, 1'b0, 1'b0);
    iniciar();
    chk("start", 8'h00, 8'h01, 8'h02, 1'b1, 1'b0);
    cyc(3);
    chk("before_tick", 8'h00, 8'h01, 8'h02, 1'b1, 1'b0);
    cyc();
    chk("tick1", 8'h00, 8'h01, 8'h01, 1'b1, 1'b0);
    cyc(4);
    chk("tick2", 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
    cyc(4);
    chk("tick3_borrow_min", 8'h00, 8'h00, 8'h59, 1'b1, 1'b0);

    // Reaching zero and alarm acknowledge
    cargar(8'h00, 8'h00, 8'h02);
    iniciar();
    cyc(4);
    chk("done_m1", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    cyc(4);
    chk("done", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(3);
    chk("done_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    bus.apagar = 1'b1;
    cyc();
    chk("apagar", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    iniciar();
    chk("start_zero_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Borrow through all three fields
    cargar(8'h01, 8'h00, 8'h00);
    iniciar();
    cyc(4);
    chk("borrow_hours", 8'h00, 8'h59, 8'h59, 1'b1, 1'b0);

    // Pause mid-second keeps the partial count
    cyc(2);
    bus.pausar = 1'b1;
    cyc();
    chk("paused", 8'h00, 8'h59, 8'h59, 1'b0, 1'b0);
    cyc(20);
    chk("paused_hold", 8'h00, 8'h59, 8'h59, 1'b0, 1'b0);
    iniciar();
    chk("resumed", 8'h00, 8'h59, 8'h59, 1'b1, 1'b0);
    cyc();
    chk("resume_no_tick", 8'h00, 8'h59, 8'h59, 1'b1, 1'b0);
    cyc();
    chk("resume_tick", 8'h00, 8'h59, 8'h58, 1'b1, 1'b0);

    // Pause coincident with a tick
    cyc(3);
    bus.pausar = 1'b1;
    cyc();
    chk("pause_on_tick", 8'h00, 8'h59, 8'h58, 1'b0, 1'b0);
    iniciar();
    chk("resume2", 8'h00, 8'h59, 8'h58, 1'b1, 1'b0);
    cyc();
    chk("resume2_tick", 8'h00, 8'h59, 8'h57, 1'b1, 1'b0);

    // Load sanitising table
    foreach (tabla[i]) begin
      cargar(tabla[i].h_in, tabla[i].m_in, tabla[i].s_in);
      chk($sformatf("sanitize_%0d", i), tabla[i].h_exp, tabla[i].m_exp, tabla[i].s_exp, 1'b0, 1'b0);
    end
    iniciar();
    chk("start_zero_idle2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Load while in DONE
    cargar(8'h00, 8'h00, 8'h01);
    iniciar();
    cyc(4);
    chk("done2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    cargar(8'h12, 8'h34, 8'h56);
    chk("load_in_done", 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);

    // Reset mid-run
    iniciar();
    cyc(2);
    reset = 1'b0;
    cyc();
    chk("reset_mid_run", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    cargar(8'h00, 8'h00, 8'h03);
    iniciar();
    cyc(4);
    chk("after_reset_tick", 8'h00, 8'h00, 8'h02, 1'b1, 1'b0);

    // Random pulses against the reference model
    for (int c = 0; c < 3000; c++) begin
      bus.carga   = ($urandom_range(0, 39) == 0);
      bus.iniciar = ($urandom_range(0, 5) == 0);
      bus.pausar  = ($urandom_range(0, 11) == 0);
      bus.apagar  = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.segundos_in = 8'($urandom);
        bus.minutos_in  = 8'($urandom);
        bus.horas_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end else begin
        bus.segundos_in = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
        bus.minutos_in  = {4'd0, 4'($urandom_range(0, 1))};
        bus.horas_in    = 8'h00;
      end
      cyc();
      chk_model("random");
    end
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
